// File: rtl/key_move_ctrl.sv
// Push-button front end for the PacMan datapath: sync, per-key debounce,
// priority select and one-hot move pulses with hold-to-repeat.
module key_move_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_n,
    output logic [3:0] key_held,
    output logic [3:0] move,
    output logic [1:0] active
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    logic [3:0]      sync1;
    logic [3:0]      sync2;
    logic [3:0]      s_prev;
    logic [3:0]      s;
    logic [DB_W-1:0] db_cnt [4];

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic [1:0]       active_nxt;
    logic [3:0]       move_nxt;
    logic [1:0]       req;
    logic             any_held;

    assign s        = ~sync2;
    assign any_held = |key_held;

    // Synchroniser and per-key debounce; s_prev flags a fresh edge on the synced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 4'b1111;
            sync2    <= 4'b1111;
            s_prev   <= 4'b0000;
            key_held <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1  <= key_n;
            sync2  <= sync1;
            s_prev <= s;
            for (int i = 0; i < 4; i++) begin
                if ((s[i] == key_held[i]) || (s[i] != s_prev[i])) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    key_held[i] <= s[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Lowest held index wins.
    always_comb begin
        req = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (key_held[i]) begin
                req = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            timer  <= '0;
            active <= 2'd0;
            move   <= 4'b0000;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            active <= active_nxt;
            move   <= move_nxt;
        end
    end

    // A switch to another key outranks a timer expiry and restarts the delay.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        active_nxt = active;
        move_nxt   = 4'b0000;
        case (state)
            IDLE: begin
                if (any_held) begin
                    move_nxt   = 4'b0001 << req;
                    active_nxt = req;
                    timer_nxt  = '0;
                    state_nxt  = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (!any_held) begin
                    state_nxt = IDLE;
                end else if (req != active) begin
                    move_nxt   = 4'b0001 << req;
                    active_nxt = req;
                    timer_nxt  = '0;
                    state_nxt  = DELAY;
                end else if (timer == ((state == DELAY) ? DELAY_LAST : RATE_LAST)) begin
                    move_nxt  = 4'b0001 << active;
                    timer_nxt = '0;
                    state_nxt = REPEAT;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_key_move_ctrl.sv
// Scoreboard bench for key_move_ctrl: expected key_held edges and move pulses are
// queued by cycle number and matched by a negedge monitor.
module tb_key_move_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic [3:0] key_held;
    logic [3:0] move;
    logic [1:0] active;

    key_move_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_RATE    (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .key_n   (key_n),
        .key_held(key_held),
        .move    (move),
        .active  (active)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } ev_t;

    ev_t        move_q[$];
    ev_t        held_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] held_prev = 4'b0000;

    task automatic exp_move(input int c, input logic [3:0] v);
        move_q.push_back('{c, v});
    endtask

    task automatic exp_held(input int c, input logic [3:0] v);
        held_q.push_back('{c, v});
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, edge_n, got, exp);
        end
    endtask

    task automatic goto(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every nonzero move and every key_held change must match the queue head.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (move !== 4'b0000) begin
            checks++;
            if (move_q.size() == 0) begin
                failures++;
                $display("FAIL move_unexpected cyc=%0d got=%b", edge_n, move);
            end else begin
                e = move_q.pop_front();
                if ((e.cyc != edge_n) || (e.val !== move)) begin
                    failures++;
                    $display("FAIL move_pulse got cyc=%0d val=%b exp cyc=%0d val=%b",
                             edge_n, move, e.cyc, e.val);
                end
            end
        end
        if (key_held !== held_prev) begin
            checks++;
            if (held_q.size() == 0) begin
                failures++;
                $display("FAIL held_unexpected cyc=%0d got=%b", edge_n, key_held);
            end else begin
                e = held_q.pop_front();
                if ((e.cyc != edge_n) || (e.val !== key_held)) begin
                    failures++;
                    $display("FAIL held_edge got cyc=%0d val=%b exp cyc=%0d val=%b",
                             edge_n, key_held, e.cyc, e.val);
                end
            end
            held_prev = key_held;
        end
    end

    initial begin
        reset = 1'b1;
        key_n = 4'b1111;
        goto(3);
        chk("reset_held", 32'(key_held), 32'd0);
        chk("reset_move", 32'(move), 32'd0);
        chk("reset_active", 32'(active), 32'd0);
        reset = 1'b0;

        // Single key held through DELAY into REPEAT, then released.
        goto(9);
        key_n = 4'b1110;
        exp_held(16, 4'b0001);
        exp_move(17, 4'b0001);
        exp_move(37, 4'b0001);
        exp_move(45, 4'b0001);
        exp_move(53, 4'b0001);
        exp_move(61, 4'b0001);
        exp_held(66, 4'b0000);
        goto(20);
        chk("active_key0", 32'(active), 32'd0);
        goto(59);
        key_n = 4'b1111;

        // Three-cycle bounce on key 1 must be filtered.
        goto(79);
        key_n = 4'b1101;
        goto(82);
        key_n = 4'b1111;
        goto(90);
        chk("bounce_held", 32'(key_held), 32'd0);

        // Up+down together: up wins, releasing up hands over to down.
        goto(99);
        key_n = 4'b0011;
        exp_held(106, 4'b1100);
        exp_move(107, 4'b0100);
        exp_held(121, 4'b1000);
        exp_move(122, 4'b1000);
        exp_move(142, 4'b1000);
        exp_held(146, 4'b0000);
        goto(110);
        chk("active_up", 32'(active), 32'd2);
        goto(114);
        key_n = 4'b0111;
        goto(125);
        chk("active_down", 32'(active), 32'd3);
        goto(139);
        key_n = 4'b1111;

        // Short release during REPEAT leaves the 8-cycle cadence intact.
        goto(169);
        key_n = 4'b1110;
        exp_held(176, 4'b0001);
        exp_move(177, 4'b0001);
        exp_move(197, 4'b0001);
        exp_move(205, 4'b0001);
        exp_move(213, 4'b0001);
        exp_move(221, 4'b0001);
        exp_move(229, 4'b0001);
        exp_held(230, 4'b0000);
        goto(199);
        key_n = 4'b1111;
        goto(202);
        key_n = 4'b1110;
        goto(223);
        key_n = 4'b1111;

        // Reset during DELAY with key 3 still held: re-debounce and fresh first pulse.
        goto(249);
        key_n = 4'b0111;
        exp_held(256, 4'b1000);
        exp_move(257, 4'b1000);
        exp_held(265, 4'b0000);
        exp_held(272, 4'b1000);
        exp_move(273, 4'b1000);
        exp_held(286, 4'b0000);
        goto(264);
        reset = 1'b1;
        goto(265);
        reset = 1'b0;
        chk("midreset_held", 32'(key_held), 32'd0);
        chk("midreset_move", 32'(move), 32'd0);
        chk("midreset_active", 32'(active), 32'd0);
        goto(279);
        key_n = 4'b1111;

        goto(300);
        chk("move_q_drained", 32'(move_q.size()), 32'd0);
        chk("held_q_drained", 32'(held_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
